// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch and sequencing unit. Reads the word at `pc` from program
// memory, turns the control-flow opcodes (JMP/JSR/RET) into PC control
// strobes, forwards every other opcode to the execute stage, then strobes the
// PC to advance.
//
// Opcode map (instr[15:12]):
//   0x0 NOP, 0x1 JMP [10:0], 0x2 JSR [9:0], 0x3 RET, 0xF HALT,
//   0x4..0xE handed to execute.
//
// Handshakes:
//   Memory:  mem_rd is a one-cycle request carrying mem_addr. The response
//            arrives on any later cycle as mem_ack=1 with mem_data; it is only
//            looked at while waiting for it.
//   Execute: instr_valid/instr_ready. instr_valid stays high and instr stays
//            stable until a cycle in which instr_ready=1; the transfer
//            happens on that rising edge. instr_ready is ignored otherwise.
//
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   pc                   current PC value from the PC block
//   pc_advance           one-cycle strobe, PC updates on this edge
//   preload/preload_addr PC loads an absolute address
//   jsr/relative_addr    PC saves return address, adds zero-extended offset
//   ret                  PC returns to saved address + 1
//   mem_addr/mem_rd      program memory read request
//   mem_ack/mem_data     program memory response
//   instr_valid/instr/instr_ready  execute handshake
//   halted               HALT executed, only reset leaves it
//   call_err             sticky: nested JSR or RET with no open call
//   fsm_state            current sequencer state, for observation
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [10:0] BOOT_ADDR = 11'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] pc,
  output logic        pc_advance,
  output logic        preload,
  output logic [10:0] preload_addr,
  output logic        jsr,
  output logic [9:0]  relative_addr,
  output logic        ret,
  output logic [10:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic        halted,
  output logic        call_err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  // Control action carried from the WAIT latch into the ADVANCE cycle.
  typedef enum logic [1:0] {
    CTL_NONE = 2'd0,
    CTL_JMP  = 2'd1,
    CTL_JSR  = 2'd2,
    CTL_RET  = 2'd3
  } ctl_t;

  state_t      state_q;
  state_t      state_d;
  ctl_t        ctl_q;
  ctl_t        ctl_d;
  logic        live_q;      // low only between reset and the first edge
  logic [15:0] instr_q;
  logic        depth_q;     // 1 while a JSR is open (PC holds one level)
  logic        depth_d;
  logic        call_err_q;
  logic        err_set;
  logic        latch_en;
  logic [3:0]  op;
  logic        op_exec;
  logic        op_halt;
  logic        boot_pulse;
  logic        in_adv;

  // -------------------------------------------------------------------------
  // Decode of the word arriving from memory. Only used on the latch cycle.
  // -------------------------------------------------------------------------
  assign op       = mem_data[15:12];
  assign op_exec  = (op >= 4'h4) && (op <= 4'hE);
  assign op_halt  = (op == 4'hF);
  assign latch_en = (state_q == S_WAIT) && mem_ack;

  always_comb begin
    ctl_d   = CTL_NONE;
    depth_d = depth_q;
    err_set = 1'b0;
    case (op)
      4'h1: ctl_d = CTL_JMP;
      4'h2: begin
        // A JSR inside an open call still executes; the PC simply
        // overwrites its single saved return address.
        ctl_d   = CTL_JSR;
        depth_d = 1'b1;
        err_set = depth_q;
      end
      4'h3: begin
        // RET with nothing open degrades to a NOP so the PC just increments.
        if (depth_q) begin
          ctl_d   = CTL_RET;
          depth_d = 1'b0;
        end else begin
          err_set = 1'b1;
        end
      end
      default: ctl_d = CTL_NONE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      // BOOT is held through the reset-release edge so its preload strobe
      // appears for one full clean cycle after release.
      S_BOOT:    if (live_q) state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ack) begin
          if (op_halt)      state_d = S_HALT;
          else if (op_exec) state_d = S_ISSUE;
          else              state_d = S_ADVANCE;
        end
      end
      S_ISSUE:   if (instr_ready) state_d = S_ADVANCE;
      S_ADVANCE: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_BOOT;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      instr_q    <= 16'd0;
      ctl_q      <= CTL_NONE;
      depth_q    <= 1'b0;
      call_err_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (latch_en) begin
        instr_q <= mem_data;
        ctl_q   <= ctl_d;
        depth_q <= depth_d;
        if (err_set) call_err_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only (state, latched word, flags).
  // -------------------------------------------------------------------------
  assign boot_pulse = (state_q == S_BOOT) && live_q;
  assign in_adv     = (state_q == S_ADVANCE);

  assign pc_advance    = boot_pulse || in_adv;
  assign preload       = boot_pulse || (in_adv && (ctl_q == CTL_JMP));
  assign preload_addr  = boot_pulse ? BOOT_ADDR :
                         (in_adv && (ctl_q == CTL_JMP)) ? instr_q[10:0] : 11'd0;
  assign jsr           = in_adv && (ctl_q == CTL_JSR);
  assign relative_addr = jsr ? instr_q[9:0] : 10'd0;
  assign ret           = in_adv && (ctl_q == CTL_RET);

  // The PC is itself a register that only settles on the ADVANCE edge just
  // before FETCH, so the request address is taken straight from it while
  // the request is up; it reads as zero at all other times.
  assign mem_rd   = (state_q == S_FETCH);
  assign mem_addr = mem_rd ? pc : 11'd0;

  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign halted      = (state_q == S_HALT);
  assign call_err    = call_err_q;
  assign fsm_state   = state_q;

endmodule
